// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, MD_RUN = 1'b1} md_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_CYCLES_DEFAULT = 32;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: tracks an in-flight multiply/divide and reports busy until its result is valid
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      launch,
  output logic      busy,
  output md_state_t state
);
  md_state_t  r_state;
  logic [7:0] r_md_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_md_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (launch) begin
        r_state  <= MD_RUN;
        r_md_cnt <= 8'(MD_CYCLES - 1);
      end
    end else if (r_md_cnt == 8'd0) begin
      r_state <= IDLE;
    end else begin
      r_md_cnt <= r_md_cnt - 8'd1;
    end
  end
  // busy is a pure state decode so it never glitches
  assign busy  = r_state == MD_RUN;
  assign state = r_state;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / mult-div / branch stall-flush control for the 5-stage core
// Optional performance counters built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread_IE,
  input  logic [4:0]       rt_addr_IE,
  input  logic [4:0]       rs_addr_ID,
  input  logic [4:0]       rt_addr_ID,
  input  logic             uses_rt_ID,
  input  logic             branch_taken_EX,
  input  logic             md_start_ID,
  input  logic             md_use_ID,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_go,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  md_state_t w_state;
  logic      w_lu, w_mdh, w_stall, w_flush;
  assign w_lu = memread_IE && rt_addr_IE != REG_ZERO &&
                (rt_addr_IE == rs_addr_ID || (uses_rt_ID && rt_addr_IE == rt_addr_ID));
  assign w_mdh   = md_busy && (md_use_ID || md_start_ID);
  // a taken branch outranks any stall; reset forces the free-running defaults
  assign w_flush = !rst && branch_taken_EX;
  assign w_stall = !rst && !branch_taken_EX && (w_lu || w_mdh);
  assign pc_we        = !w_stall;
  assign if_id_we     = !w_stall;
  assign if_id_flush  = w_flush;
  assign id_ex_bubble = w_flush || w_stall;
  assign md_go = !rst && w_state == IDLE && md_start_ID && !branch_taken_EX && !w_lu;
  md_busy_timer #(.MD_CYCLES(MD_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .launch(md_go),
    .busy  (md_busy),
    .state (w_state)
  );
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_we && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (if_id_flush && !(&r_flush_count)) r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl (MD_CYCLES=4, CNT_W=2)
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       memread_IE = 0, uses_rt_ID = 0, branch_taken_EX = 0, md_start_ID = 0, md_use_ID = 0;
  logic [4:0] rt_addr_IE = 0, rs_addr_ID = 0, rt_addr_ID = 0;
  logic       pc_we, if_id_we, if_id_flush, id_ex_bubble, md_go, md_busy;
  logic [1:0] stall_cycles, flush_count;
  logic [5:0] obs;
  int         tests = 0, fails = 0;
  localparam logic [5:0] RUN = 6'b110000, STL = 6'b000100, FLS = 6'b111100,
                         GO = 6'b110010, BSTL = 6'b000101;
  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .memread_IE(memread_IE), .rt_addr_IE(rt_addr_IE),
    .rs_addr_ID(rs_addr_ID), .rt_addr_ID(rt_addr_ID), .uses_rt_ID(uses_rt_ID),
    .branch_taken_EX(branch_taken_EX), .md_start_ID(md_start_ID), .md_use_ID(md_use_ID),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .md_go(md_go), .md_busy(md_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  assign obs = {pc_we, if_id_we, if_id_flush, id_ex_bubble, md_go, md_busy};
  always #5 clk = ~clk;
  task automatic clear_in;
    memread_IE = 0; uses_rt_ID = 0; branch_taken_EX = 0; md_start_ID = 0; md_use_ID = 0;
    rt_addr_IE = 0; rs_addr_ID = 0; rt_addr_ID = 0;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    clear_in(); rst = 1; md_start_ID = 1; md_use_ID = 1; #2;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", obs, RUN); end
    tests++;
    if ({stall_cycles, flush_count} !== 4'b0) begin fails++; $display("FAIL reset_counters got=%b exp=0000", {stall_cycles, flush_count}); end
    @(posedge clk); #1; rst = 0; clear_in(); #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL post_reset got=%b exp=%b", obs, RUN); end
  endtask
  task automatic test_load_use;
    step(); memread_IE = 1; rt_addr_IE = 9; rs_addr_ID = 9; #1;
    tests++;
    if (obs !== STL) begin fails++; $display("FAIL lu_rs got=%b exp=%b", obs, STL); end
    step(); clear_in(); #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL lu_release got=%b exp=%b", obs, RUN); end
    memread_IE = 1; rt_addr_IE = 9; rs_addr_ID = 4; rt_addr_ID = 9; uses_rt_ID = 1; #1;
    tests++;
    if (obs !== STL) begin fails++; $display("FAIL lu_rt got=%b exp=%b", obs, STL); end
  endtask
  task automatic test_no_stall;
    step(); clear_in(); memread_IE = 1; rt_addr_IE = 0; rs_addr_ID = 0; rt_addr_ID = 0; uses_rt_ID = 1; #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL lu_r0 got=%b exp=%b", obs, RUN); end
    rt_addr_IE = 9; rs_addr_ID = 4; rt_addr_ID = 9; uses_rt_ID = 0; #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL lu_no_rt got=%b exp=%b", obs, RUN); end
    memread_IE = 0; rs_addr_ID = 9; #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL no_load got=%b exp=%b", obs, RUN); end
  endtask
  task automatic test_md;
    step(); clear_in(); md_start_ID = 1; #1;
    tests++;
    if (obs !== GO) begin fails++; $display("FAIL md_go got=%b exp=%b", obs, GO); end
    for (int c = 1; c <= 4; c++) begin
      step(); md_start_ID = 0; md_use_ID = 1; #1;
      tests++;
      if (obs !== BSTL) begin fails++; $display("FAIL md_busy_c%0d got=%b exp=%b", c, obs, BSTL); end
    end
    step(); #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL md_release got=%b exp=%b", obs, RUN); end
  endtask
  task automatic test_back_to_back;
    step(); clear_in(); md_start_ID = 1; #1;
    tests++;
    if (obs !== GO) begin fails++; $display("FAIL b2b_go1 got=%b exp=%b", obs, GO); end
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      tests++;
      if (obs !== BSTL) begin fails++; $display("FAIL b2b_stall_c%0d got=%b exp=%b", c, obs, BSTL); end
    end
    step(); #1;
    tests++;
    if (obs !== GO) begin fails++; $display("FAIL b2b_go2 got=%b exp=%b", obs, GO); end
    step(); md_start_ID = 0; #1;
    tests++;
    if (obs !== 6'b110001) begin fails++; $display("FAIL b2b_busy2 got=%b exp=110001", obs); end
    repeat (4) step();
  endtask
  task automatic test_branch;
    step(); clear_in(); memread_IE = 1; rt_addr_IE = 9; rs_addr_ID = 9; md_start_ID = 1; branch_taken_EX = 1; #1;
    tests++;
    if (obs !== FLS) begin fails++; $display("FAIL branch_prio got=%b exp=%b", obs, FLS); end
    step(); clear_in(); #1;
    tests++;
    if (md_busy !== 1'b0) begin fails++; $display("FAIL branch_idle got=%b exp=0", md_busy); end
  endtask
  task automatic test_reset_mid_md;
    step(); clear_in(); md_start_ID = 1; #1;
    step(); md_start_ID = 0; md_use_ID = 1;
    step(); #1;
    tests++;
    if (obs !== BSTL) begin fails++; $display("FAIL rmid_pre got=%b exp=%b", obs, BSTL); end
    rst = 1; md_start_ID = 1; #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL rmid_async got=%b exp=%b", obs, RUN); end
    step(); rst = 0; md_start_ID = 0; step(); #1;
    tests++;
    if (obs !== RUN) begin fails++; $display("FAIL rmid_after got=%b exp=%b", obs, RUN); end
  endtask
  task automatic test_perf;
    logic [1:0] es, ef;
    clear_in(); rst = 1; step(); rst = 0;
    memread_IE = 1; rt_addr_IE = 9; rs_addr_ID = 9;
    repeat (3) @(posedge clk); #1; clear_in(); #1;
`ifdef PIPE_CTRL_PERF_EN
    es = 2'd3; ef = 2'd0;
`else
    es = 2'd0; ef = 2'd0;
`endif
    tests++;
    if ({stall_cycles, flush_count} !== {es, ef}) begin fails++; $display("FAIL perf_stall got=%b exp=%b", {stall_cycles, flush_count}, {es, ef}); end
    branch_taken_EX = 1;
    repeat (2) @(posedge clk); #1; clear_in(); #1;
`ifdef PIPE_CTRL_PERF_EN
    ef = 2'd2;
`endif
    tests++;
    if ({stall_cycles, flush_count} !== {es, ef}) begin fails++; $display("FAIL perf_flush got=%b exp=%b", {stall_cycles, flush_count}, {es, ef}); end
    memread_IE = 1; rt_addr_IE = 9; rs_addr_ID = 9;
    repeat (2) @(posedge clk); #1; clear_in(); #1;
    tests++;
    if ({stall_cycles, flush_count} !== {es, ef}) begin fails++; $display("FAIL perf_sat got=%b exp=%b", {stall_cycles, flush_count}, {es, ef}); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_md();
    test_back_to_back();
    test_branch();
    test_reset_mid_md();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
